dumpoff_gen: RTL
================

Name: dumpoff_gen

Overview:
- Upstream stage of the dump-off output mux. Generates timed dump-off pulse trains that damp coil ringing after each RF pulse.
- Drives the mux select `change[1:0]` and the three per-channel dump-off inputs.
- Guarantees `change` is stable before and throughout every pulse, so the downstream mux never switches channel mid-pulse.
- Triggered by the pulse-sequence controller once per echo train.

Parameters:
- CNT_W, 16: width of the delay, width and period counters (clock cycles).
- NUM_W, 8: width of the pulse-count field.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- ch_sel  input  2  target channel (0..2). Value 3 is illegal.
- delay  input  CNT_W  cycles from start acceptance to first pulse.
- width  input  CNT_W  pulse high time, in cycles.
- period  input  CNT_W  rising-edge-to-rising-edge spacing, in cycles.
- num  input  NUM_W  number of pulses in the train.
- change  output  2  mux select; registered.
- dumpoffin0  output  1  channel-0 pulse; registered.
- dumpoffin1  output  1  channel-1 pulse; registered.
- dumpoffin2  output  1  channel-2 pulse; registered.
- busy  output  1  high from start acceptance until return to IDLE.
- done  output  1  one-cycle pulse at train completion or rejection.
- err  output  1  sticky: illegal configuration rejected. Cleared by the next accepted start, or by rst.

Behaviour:
- Reset values: state=IDLE, change=0, all dumpoffin*=0, busy=0, done=0, err=0. Reset mid-train aborts immediately; no partial pulse survives.
- Configuration capture:
  - At the start edge in IDLE, latch ch_sel, delay, width, period and num.
  - Inputs changing afterwards are ignored until the next IDLE.
  - start outside IDLE is ignored.
- Rejection:
  - Triggered if ch_sel==3, width==0 or num==0.
  - Next cycle: done=1, err=1, busy stays 0, no pulse is emitted, change is unchanged, state stays IDLE.
- Accepted start:
  - change <= ch_sel and busy <= 1 on the same edge.
  - err cleared.
  - Go to DELAY.
- States:
  - IDLE: wait for start, as above.
  - DELAY: counts delay cycles. delay==0 goes straight to PULSE.
  - PULSE: the selected dumpoffin is high for exactly width cycles; the other two stay 0.
  - GAP: low for gap = period-width cycles. If period<=width, gap is forced to 1 cycle.
  - DONE: one cycle; done=1, busy=0 on the following edge, then back to IDLE.
- Train sequencing:
  - After each PULSE, decrement the remaining count.
  - If it reaches 0, go to DONE (no trailing gap). Otherwise go to GAP, then PULSE.
- Timing: with start sampled at edge T0, the first pulse is high in the cycles after edges T0+delay+1 through T0+delay+width.
- change is held from acceptance until the next accepted start. It is never altered by a rejected start.
- Counters:
  - Unsigned, CNT_W bits, load-and-decrement.
  - No wrap-around. The maximum field value is honoured exactly.
  - The pulse counter is NUM_W bits.

Optional Feature:
- Macro: DOFF_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit).
  - abort=1 in any non-IDLE state: the next edge drives all dumpoffin* to 0, sets err=1, pulses done for 1 cycle and returns to IDLE.
  - In IDLE, abort has priority over a simultaneous start.
- When undefined: no port; trains always run to completion, or until rst.

Decomposition:
- Shared package doff_pkg:
  - State encoding: IDLE/DELAY/PULSE/GAP/DONE.
  - Channel constants CH0..CH2 and CH_ILLEGAL=3.
  - Default CNT_W/NUM_W values.
- One sub-module, doff_cnt: loadable down-counter with a zero flag. Instantiated for the phase counter (delay/width/gap) and for the pulse-count counter.

Test Plan:
- ch_sel=1, delay=4, width=3, period=10, num=2, start at T0 -> change=1 at T0+1; dumpoffin1 high during cycles T0+5..T0+7 and T0+15..T0+17; done at T0+18; dumpoffin0/2 always 0.
- ch_sel=3 with otherwise valid fields -> next cycle done=1, err=1, busy=0, no pulses, change unchanged.
- delay=0, width=1, period=1, num=3, ch_sel=2 -> three 1-cycle pulses on dumpoffin2 separated by 1-cycle gaps, starting at T0+1.
- start re-asserted mid-train with ch_sel=0 -> ignored; change stays at the original channel; train completes normally.
- rst asserted during PULSE -> next edge: all outputs 0, change=0, state IDLE; subsequent start works normally.
- (DOFF_ABORT_EN) abort during GAP of a num=5 train -> outputs 0, err=1, done pulse, no further pulses.

Source files
------------

// File: rtl/doff_pkg.sv
// Shared definitions for the dump-off pulse generator: FSM states, channel codes and default widths.
package doff_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;
    localparam int NUM_CH    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } doff_state_e;

    localparam logic [1:0] CH0        = 2'd0;
    localparam logic [1:0] CH1        = 2'd1;
    localparam logic [1:0] CH2        = 2'd2;
    localparam logic [1:0] CH_ILLEGAL = 2'd3;

    // A train request is refused outright if it targets no real channel or would emit nothing.
    function automatic logic cfg_illegal(input logic [1:0] ch, input logic width_zero, input logic num_zero);
        return (ch == CH_ILLEGAL) || width_zero || num_zero;
    endfunction

endpackage

// File: rtl/doff_cnt.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module doff_cnt
    import doff_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dumpoff_gen.sv
// Dump-off pulse-train generator feeding the output mux select and per-channel dump-off lines.
// Optional DOFF_ABORT_EN adds an abort input that kills a running train and flags err.
module dumpoff_gen
    import doff_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ch_sel,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    input  logic [NUM_W-1:0] num,
`ifdef DOFF_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       change,
    output logic             dumpoffin0,
    output logic             dumpoffin1,
    output logic             dumpoffin2,
    output logic             busy,
    output logic             done,
    output logic             err
);

    doff_state_e state_q, state_d;

    logic [1:0]        change_q, change_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  gap_q, gap_d;

    logic              ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0]  ph_val;
    logic              pc_load, pc_dec, pc_zero;
    logic [NUM_W-1:0]  pc_val;

    logic              accept, reject, abort_hit, abort_req, illegal;
    logic [CNT_W-1:0]  gap_in;

`ifdef DOFF_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign illegal = cfg_illegal(ch_sel, width == '0, num == '0);
    // Low time between pulses; a period no longer than the pulse still leaves one low cycle.
    assign gap_in  = (period > width) ? (period - width) : CNT_W'(1);

    doff_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (ph_load),
        .val_i  (ph_val),
        .dec_i  (ph_dec),
        .zero_o (ph_zero)
    );

    doff_cnt #(.W(NUM_W)) u_pulse_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .val_i  (pc_val),
        .dec_i  (pc_dec),
        .zero_o (pc_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters hold "cycles remaining minus one", so a phase ends on the zero flag.
    always_comb begin
        state_d   = state_q;
        ph_load   = 1'b0;
        ph_dec    = 1'b0;
        ph_val    = '0;
        pc_load   = 1'b0;
        pc_dec    = 1'b0;
        pc_val    = '0;
        accept    = 1'b0;
        reject    = 1'b0;
        abort_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort_req) begin
                    if (illegal) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        pc_load = 1'b1;
                        pc_val  = num - NUM_W'(1);
                        ph_load = 1'b1;
                        if (delay == '0) begin
                            state_d = ST_PULSE;
                            ph_val  = width - CNT_W'(1);
                        end else begin
                            state_d = ST_DELAY;
                            ph_val  = delay - CNT_W'(1);
                        end
                    end
                end
            end
            ST_DELAY, ST_GAP: begin
                if (ph_zero) begin
                    state_d = ST_PULSE;
                    ph_load = 1'b1;
                    ph_val  = width_q - CNT_W'(1);
                end else begin
                    ph_dec = 1'b1;
                end
            end
            ST_PULSE: begin
                if (!ph_zero) begin
                    ph_dec = 1'b1;
                end else if (pc_zero) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP;
                    pc_dec  = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = gap_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_req && (state_q != ST_IDLE)) begin
            abort_hit = 1'b1;
            state_d   = ST_IDLE;
            ph_load   = 1'b0;
            ph_dec    = 1'b0;
            pc_load   = 1'b0;
            pc_dec    = 1'b0;
        end
    end

    always_comb begin
        change_d = accept ? ch_sel : change_q;
        width_d  = accept ? width : width_q;
        gap_d    = accept ? gap_in : gap_q;
        busy_d   = (state_d != ST_IDLE);
        done_d   = reject || abort_hit || (state_q == ST_DONE);
        err_d    = err_q;
        if (reject || abort_hit) begin
            err_d = 1'b1;
        end else if (accept) begin
            err_d = 1'b0;
        end
    end

    // change_q is frozen for the whole train, so it safely steers the pulse to one line.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign pulse_d[gi] = (state_q == ST_PULSE) && !abort_hit && (change_q == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            change_q <= '0;
            pulse_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            width_q  <= '0;
            gap_q    <= '0;
        end else begin
            change_q <= change_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
        end
    end

    assign change     = change_q;
    assign dumpoffin0 = pulse_q[0];
    assign dumpoffin1 = pulse_q[1];
    assign dumpoffin2 = pulse_q[2];
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
